// File: rtl/fp_pkg.sv
// Shared widths, limits and packing helper for the 8-bit minifloat round/pack path.
package fp_pkg;

  localparam int EXP_W     = 3;
  localparam int SIG_W     = 4;
  localparam int OUT_W     = 8;
  localparam int SAT_CNT_W = 8;

  localparam logic [EXP_W-1:0]     E_MAX       = 3'b111;
  localparam logic [SIG_W-1:0]     F_MAX       = 4'b1111;
  localparam logic [SIG_W-1:0]     F_CARRY     = 4'b1000;
  localparam logic [SAT_CNT_W-1:0] SAT_CNT_MAX = 8'd255;

  // A zero magnitude always packs as +0 so that a negative zero never leaves the block.
  function automatic logic [OUT_W-1:0] pack_float(input logic s,
                                                  input logic [EXP_W-1:0] e,
                                                  input logic [SIG_W-1:0] f);
    if (e == '0 && f == '0) return '0;
    return {s, e, f};
  endfunction

endpackage

// File: rtl/fp_round.sv
// Combinational round-half-up of an {E, F} pair using the first discarded bit.
module fp_round
  import fp_pkg::*;
(
  input  logic [EXP_W-1:0] e_in,
  input  logic [SIG_W-1:0] f_in,
  input  logic             fifth_bit,
  output logic [EXP_W-1:0] e_out,
  output logic [SIG_W-1:0] f_out,
  output logic             sat
);

  // A significand carry renormalises to 1000 in the next binade; at the top binade we clamp instead.
  always_comb begin
    e_out = e_in;
    f_out = f_in;
    sat   = 1'b0;
    if (fifth_bit) begin
      if (f_in == F_MAX) begin
        if (e_in == E_MAX) begin
          sat = 1'b1;
        end else begin
          e_out = e_in + 1'b1;
          f_out = F_CARRY;
        end
      end else begin
        f_out = f_in + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_round_pack.sv
// Two-stage valid/ready pipeline: S1 rounds and packs, S2 is the output register.
module fp_round_pack
  import fp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sign,
  input  logic [EXP_W-1:0]     exponent,
  input  logic [SIG_W-1:0]     significand,
  input  logic                 fifth_bit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_float,
  output logic                 out_sat,
  input  logic                 sat_clr,
  output logic [SAT_CNT_W-1:0] sat_count
);

  logic [EXP_W-1:0] e_rnd;
  logic [SIG_W-1:0] f_rnd;
  logic             sat_rnd;

  logic             s1_valid;
  logic [OUT_W-1:0] s1_float;
  logic             s1_sat;
  logic             s2_valid;

  logic             s1_adv;
  logic             s2_adv;
  logic             out_xfer;

  fp_round u_round (
    .e_in      (exponent),
    .f_in      (significand),
    .fifth_bit (fifth_bit),
    .e_out     (e_rnd),
    .f_out     (f_rnd),
    .sat       (sat_rnd)
  );

  // in_ready is masked by rst because the cleared stages would otherwise look free during reset.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv && !rst;
  assign out_valid = s2_valid;
  assign out_xfer  = s2_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_float <= '0;
      s1_sat   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_float <= pack_float(sign, e_rnd, f_rnd);
        s1_sat   <= sat_rnd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      out_float <= '0;
      out_sat   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_float <= s1_float;
        out_sat   <= s1_sat;
      end
    end
  end

  // Clear wins over a coincident increment; the count sticks at its maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (out_xfer && out_sat && sat_count != SAT_CNT_MAX) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_round_pack.sv
// Self-checking bench for fp_round_pack: vector table, directed corner sequences and random traffic vs a scoreboard.
module tb_fp_round_pack;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       sign;
  logic [2:0] exponent;
  logic [3:0] significand;
  logic       fifth_bit;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_float;
  logic       out_sat;
  logic       sat_clr;
  logic [7:0] sat_count;

  fp_round_pack dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sign        (sign),
    .exponent    (exponent),
    .significand (significand),
    .fifth_bit   (fifth_bit),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_float   (out_float),
    .out_sat     (out_sat),
    .sat_clr     (sat_clr),
    .sat_count   (sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] flt;
    logic       sat;
    int         cyc;
  } exp_t;

  typedef struct {
    logic       s;
    logic [2:0] e;
    logic [3:0] f;
    logic       fb;
    logic [7:0] flt;
    logic       sat;
  } vec_t;

  exp_t       sb[$];
  vec_t       tbl[11];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         sat_model = 0;
  int         out_seen = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_float = 8'h00;
  logic       prev_sat = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Value-level rounding: add the discarded bit to the significand and renormalise on overflow.
  function automatic logic [8:0] refModel(input logic s, input logic [2:0] e,
                                          input logic [3:0] f, input logic fb);
    int ee;
    int ff;
    int sat;
    int v;
    ee  = e;
    ff  = f + fb;
    sat = 0;
    if (ff > 15) begin
      if (ee == 7) begin
        ff  = 15;
        sat = 1;
      end else begin
        ee = ee + 1;
        ff = 8;
      end
    end
    v = (ee == 0 && ff == 0) ? 0 : s * 128 + ee * 16 + ff;
    return 9'(sat * 256 + v);
  endfunction

  // Runs once per cycle between edges: checks what is visible now and predicts the next edge.
  task automatic monitor();
    exp_t       e;
    logic [8:0] r;
    logic       will_clr;
    cyc++;
    if (rst) begin
      sb.delete();
      sat_model  = 0;
      prev_stall = 1'b0;
      checkOutput("in_ready_in_reset", in_ready, 0);
      checkOutput("out_valid_in_reset", out_valid, 0);
      checkOutput("sat_count_in_reset", sat_count, 0);
      return;
    end
    checkOutput("sat_count", sat_count, sat_model);
    if (prev_stall) begin
      checkOutput("stall_valid", out_valid, 1);
      checkOutput("stall_float", out_float, prev_float);
      checkOutput("stall_sat", out_sat, prev_sat);
    end
    if (sb.size() == 0) checkOutput("idle_out_valid", out_valid, 0);
    checkOutput("in_ready", in_ready, (sb.size() == 2 && !out_ready) ? 0 : 1);
    will_clr = sat_clr;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_output", out_valid, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("out_float", out_float, e.flt);
        checkOutput("out_sat", out_sat, e.sat);
        checkOutput("latency_min", (cyc - e.cyc) >= 2, 1);
        out_seen++;
        if (!will_clr && e.sat && sat_model < 255) sat_model++;
      end
    end
    if (will_clr) sat_model = 0;
    if (in_valid && in_ready) begin
      r     = refModel(sign, exponent, significand, fifth_bit);
      e.flt = r[7:0];
      e.sat = r[8];
      e.cyc = cyc;
      sb.push_back(e);
    end
    prev_stall = out_valid && !out_ready;
    prev_float = out_float;
    prev_sat   = out_sat;
  endtask

  task automatic applyStimulus(input logic r, input logic iv, input logic s, input logic [2:0] e,
                               input logic [3:0] f, input logic fb, input logic ordy, input logic clr);
    @(negedge clk);
    rst         = r;
    in_valid    = iv;
    sign        = s;
    exponent    = e;
    significand = f;
    fifth_bit   = fb;
    out_ready   = ordy;
    sat_clr     = clr;
    #1;
    monitor();
  endtask

  // Idles with out_ready high until out_valid shows, returning how many cycles that took.
  task automatic waitOutput(output int waited);
    logic found;
    found  = 1'b0;
    waited = 0;
    for (int k = 0; k < 6 && !found; k++) begin
      applyStimulus(0, 0, 0, 3'd0, 4'd0, 0, 1, 0);
      waited++;
      if (out_valid) found = 1'b1;
    end
  endtask

  initial begin
    int         waited;
    int         sent;
    int         seen0;
    logic [5:0] pat;
    logic       iv;
    logic       ordy;
    logic       clr;
    logic       s;
    logic       fb;
    logic [2:0] e;
    logic [3:0] f;

    rst = 1'b1; in_valid = 1'b0; sign = 1'b0; exponent = '0; significand = '0;
    fifth_bit = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;

    tbl[0]  = '{1'b0, 3'd3, 4'hB, 1'b1, 8'h3C, 1'b0};
    tbl[1]  = '{1'b0, 3'd3, 4'hF, 1'b1, 8'h48, 1'b0};
    tbl[2]  = '{1'b1, 3'd7, 4'hF, 1'b1, 8'hFF, 1'b1};
    tbl[3]  = '{1'b1, 3'd0, 4'h0, 1'b0, 8'h00, 1'b0};
    tbl[4]  = '{1'b0, 3'd5, 4'h6, 1'b0, 8'h56, 1'b0};
    tbl[5]  = '{1'b1, 3'd2, 4'h9, 1'b1, 8'hAA, 1'b0};
    tbl[6]  = '{1'b0, 3'd7, 4'hE, 1'b1, 8'h7F, 1'b0};
    tbl[7]  = '{1'b1, 3'd7, 4'hF, 1'b0, 8'hFF, 1'b0};
    tbl[8]  = '{1'b0, 3'd0, 4'hF, 1'b1, 8'h18, 1'b0};
    tbl[9]  = '{1'b1, 3'd0, 4'h0, 1'b1, 8'h81, 1'b0};
    tbl[10] = '{1'b1, 3'd6, 4'hF, 1'b1, 8'hF8, 1'b0};

    for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 3'd0, 4'd0, 0, 0, 0);
    checkOutput("reset_out_float", out_float, 8'h00);
    checkOutput("reset_out_sat", out_sat, 0);
    applyStimulus(0, 0, 0, 3'd0, 4'd0, 0, 1, 0);

    $display("[TB] vector table");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(0, 1, tbl[i].s, tbl[i].e, tbl[i].f, tbl[i].fb, 1, 0);
      waitOutput(waited);
      checkOutput($sformatf("tbl%0d_latency", i), waited, 2);
      checkOutput($sformatf("tbl%0d_float", i), out_float, tbl[i].flt);
      checkOutput($sformatf("tbl%0d_sat", i), out_sat, tbl[i].sat);
    end
    checkOutput("tbl_sat_count", sat_count, 1);

    $display("[TB] backpressure sequence");
    pat   = 6'b101001;
    sent  = 0;
    seen0 = out_seen;
    for (int k = 0; k < 40 && (sent < 6 || sb.size() > 0); k++) begin
      ordy = (k < 6) ? pat[k] : 1'b1;
      iv   = (sent < 6);
      applyStimulus(0, iv, sent[0], 3'(sent + 1), 4'(sent * 2 + 3), sent[1], ordy, 0);
      if (iv && in_ready) sent++;
    end
    checkOutput("bp_outputs", out_seen - seen0, 6);
    checkOutput("bp_drained", sb.size(), 0);

    $display("[TB] saturation counter");
    applyStimulus(0, 0, 0, 3'd0, 4'd0, 0, 1, 1);
    sent  = 0;
    seen0 = out_seen;
    for (int k = 0; k < 300 && (out_seen - seen0) < 257; k++) begin
      iv  = (sent < 257);
      clr = ((out_seen - seen0) == 256);
      applyStimulus(0, iv, 1, 3'd7, 4'hF, 1, 1, clr);
      if (clr) begin
        checkOutput("sat_cnt_pre_clr", sat_count, 255);
        checkOutput("sat_clr_coincident", out_valid, 1);
      end
      if (iv && in_ready) sent++;
    end
    applyStimulus(0, 0, 0, 3'd0, 4'd0, 0, 1, 0);
    checkOutput("sat_cnt_after_clr", sat_count, 0);

    $display("[TB] random traffic");
    for (int k = 0; k < 400; k++) begin
      iv   = ($urandom_range(0, 3) != 0);
      s    = 1'($urandom_range(0, 1));
      e    = 3'($urandom_range(0, 7));
      f    = 4'($urandom_range(0, 15));
      fb   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        e  = 3'd7;
        f  = 4'hF;
        fb = 1'b1;
      end
      ordy = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 40) == 0);
      applyStimulus(0, iv, s, e, f, fb, ordy, clr);
    end
    for (int k = 0; k < 10 && sb.size() > 0; k++) applyStimulus(0, 0, 0, 3'd0, 4'd0, 0, 1, 0);
    checkOutput("random_drained", sb.size(), 0);

    $display("[TB] reset with both stages full");
    applyStimulus(0, 1, 0, 3'd2, 4'h5, 0, 0, 0);
    applyStimulus(0, 1, 1, 3'd4, 4'hA, 1, 0, 0);
    applyStimulus(0, 1, 0, 3'd6, 4'h3, 0, 0, 0);
    checkOutput("full_in_ready", in_ready, 0);
    checkOutput("full_out_valid", out_valid, 1);
    applyStimulus(1, 1, 0, 3'd6, 4'h3, 0, 0, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_float", out_float, 8'h00);
    applyStimulus(1, 0, 0, 3'd0, 4'd0, 0, 1, 0);
    applyStimulus(0, 1, 1, 3'd0, 4'h0, 0, 1, 0);
    waitOutput(waited);
    checkOutput("post_rst_latency", waited, 2);
    checkOutput("post_rst_float", out_float, 8'h00);
    applyStimulus(0, 0, 0, 3'd0, 4'd0, 0, 1, 0);
    checkOutput("post_rst_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_round_pack.md
FP_ROUND_PACK -- requirements
Module: fp_round_pack

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port in_valid  input  1  upstream holds a valid sign/exponent/significand/fifth_bit tuple.
REQ-004 SHALL have port in_ready  output  1  block accepts the tuple this cycle; transfer = in_valid & in_ready.
REQ-005 SHALL have port sign  input  1  sign of the original 12-bit sample (1 = negative).
REQ-006 SHALL have port exponent  input  3  exponent from the leading-zero/extract stage.
REQ-007 SHALL have port significand  input  4  truncated significand from the extract stage.
REQ-008 SHALL have port fifth_bit  input  1  first discarded bit, used for rounding.
REQ-009 SHALL have port out_valid  output  1  out_float holds a valid result.
REQ-010 SHALL have port out_ready  input  1  downstream accepts; transfer = out_valid & out_ready.
REQ-011 SHALL have port out_float  output  8  packed result {S, E[2:0], F[3:0]}.
REQ-012 SHALL have port out_sat  output  1  result accompanying out_float was saturated.
REQ-013 SHALL have port sat_clr  input  1  synchronous clear of sat_count.
REQ-014 SHALL have port sat_count  output  8  count of saturated results transferred out, saturating at 255.

Function
REQ-015 SHALL round: fifth_bit=0 -> E,F unchanged; fifth_bit=1 -> F+1.
REQ-016 SHALL, when F=4'b1111 and fifth_bit=1, produce F=4'b1000 and E+1.
REQ-017 SHALL, when E=3'b111, F=4'b1111 and fifth_bit=1, produce E=3'b111, F=4'b1111 and assert out_sat.
REQ-018 SHALL force out_float to 8'h00 when the rounded E and F are both zero (no negative zero).
REQ-019 SHALL be a 2-stage pipeline (S1 = round, S2 = output register); latency from input transfer to out_valid SHALL be 2 cycles when out_ready is held high.
REQ-020 SHALL advance S2 when !out_valid | out_ready, and S1 when S1 is empty or S2 advances; in_ready SHALL equal the S1-advance condition.
REQ-021 SHALL sustain one transfer per cycle with out_ready held high.
REQ-022 SHALL hold out_float, out_sat and out_valid stable while out_valid & !out_ready.
REQ-023 SHALL never drop or duplicate a tuple under any out_ready pattern; order SHALL be preserved.
REQ-024 SHALL increment sat_count on each output transfer with out_sat=1, holding at 255.
REQ-025 SHALL give sat_clr priority over a simultaneous increment: the count becomes 0.
REQ-026 SHALL ignore sign, exponent, significand and fifth_bit when in_valid=0.

Reset
REQ-027 SHALL, on rst, asynchronously clear both stage valid bits, out_float=8'h00, out_sat=0, sat_count=0.
REQ-028 SHALL, while rst is high, drive in_ready=0 and out_valid=0.
REQ-029 SHALL discard in-flight tuples when rst asserts mid-operation; the first accepted tuple after release appears 2 cycles later.

Structure
REQ-030 SHALL take widths (EXP_W=3, SIG_W=4, OUT_W=8), E_MAX=3'b111, F_MAX=4'b1111 and SAT_CNT_MAX=255 from a shared package fp_pkg.
REQ-031 SHALL instantiate one combinational sub-module fp_round (E, F, fifth_bit -> E', F', sat) inside S1.

Verification
REQ-032 SHALL cover: sign=0, E=3, F=1011, fifth=1, out_ready=1 -> out_float=8'h3C, out_sat=0, 2 cycles after transfer.
REQ-033 SHALL cover: sign=0, E=3, F=1111, fifth=1 -> out_float=8'h48 (mantissa overflow carries into E).
REQ-034 SHALL cover: sign=1, E=7, F=1111, fifth=1 -> out_float=8'hFF, out_sat=1, sat_count increments by 1 on transfer.
REQ-035 SHALL cover: 6 back-to-back tuples with out_ready toggling 1,0,0,1,0,1... -> all 6 results out in order, none lost, outputs stable while stalled, in_ready=0 when both stages full and out_ready=0.
REQ-036 SHALL cover: 256 saturating transfers then sat_clr coincident with a 257th -> sat_count holds 255, then reads 0.
REQ-037 SHALL cover: rst asserted with both stages full -> out_valid=0 immediately; sign=1, E=0, F=0, fifth=0 after release -> out_float=8'h00.
